// File: rtl/ccip_feature_list_pkg.sv
// CCI-P device feature header layout plus the walker's error and state encodings.
package ccip_feature_list_pkg;

  typedef logic [3:0]  t_ccip_feature_type;
  typedef logic [11:0] t_ccip_feature_id;

  localparam t_ccip_feature_type FTYP_AFU = 4'h1;
  localparam t_ccip_feature_type FTYP_BBB = 4'h2;
  localparam t_ccip_feature_type FTYP_PVT = 4'h3;

  typedef struct packed {
    t_ccip_feature_type f_type;   // 63:60
    logic [18:0]        reserved; // 59:41
    logic               eol;      // 40
    logic [23:0]        next;     // 39:16, byte offset to the next header
    logic [3:0]         afu_rev;  // 15:12
    t_ccip_feature_id   id;       // 11:0
  } t_ccip_dfh;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_LOOP    = 2'd2,
    ERR_ADDR    = 2'd3
  } t_dfh_walk_err;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } t_dfh_walk_state;

endpackage

// File: rtl/ccip_dfh_walker.sv
// Walks a CCI-P device feature list over a single-outstanding MMIO read port and
// reports the first header matching a target type/id, or why the walk stopped.
module ccip_dfh_walker
  import ccip_feature_list_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int MAX_FEATURES = 64,
  parameter int RSP_TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        target_type,
  input  logic [11:0]       target_id,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_req_ready,
  input  logic              rd_rsp_valid,
  input  logic [63:0]       rd_rsp_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] found_addr,
  output logic [63:0]       found_dfh,
  output logic [7:0]        feature_count,
  output logic [1:0]        err
);

  localparam int TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  t_dfh_walk_state    state;
  logic [TW-1:0]      timer;
  logic [ADDR_W-1:0]  cur;
  t_ccip_feature_type tgt_type;
  t_ccip_feature_id   tgt_id;
  t_ccip_dfh          dfh;

  logic [ADDR_W:0] next_sum;
  logic [7:0]      cnt_inc;
  logic            is_match;

  // The extra top bit of the sum is the carry that flags a walk off the address space.
  assign next_sum = {1'b0, cur} + (ADDR_W + 1)'(dfh.next);
  assign cnt_inc  = feature_count + 8'd1;
  assign is_match = (dfh.f_type == tgt_type) && (dfh.id == tgt_id);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      timer         <= '0;
      cur           <= '0;
      tgt_type      <= '0;
      tgt_id        <= '0;
      dfh           <= '0;
      rd_req_valid  <= 1'b0;
      rd_req_addr   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      found_addr    <= '0;
      found_dfh     <= '0;
      feature_count <= '0;
      err           <= ERR_NONE;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tgt_type      <= target_type;
            tgt_id        <= target_id;
            cur           <= base_addr;
            found         <= 1'b0;
            found_addr    <= '0;
            found_dfh     <= '0;
            feature_count <= '0;
            err           <= ERR_NONE;
            busy          <= 1'b1;
            rd_req_valid  <= 1'b1;
            rd_req_addr   <= base_addr;
            state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rd_req_ready) begin
            rd_req_valid <= 1'b0;
            timer        <= '0;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rd_rsp_valid) begin
            dfh   <= t_ccip_dfh'(rd_rsp_data);
            state <= ST_CHECK;
          end else if (timer == TW'(RSP_TIMEOUT - 1)) begin
            err   <= ERR_TIMEOUT;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_CHECK: begin
          feature_count <= cnt_inc;
          if (is_match) begin
            found      <= 1'b1;
            found_addr <= cur;
            found_dfh  <= dfh;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
          end else if (dfh.eol || (dfh.next == '0)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if ((dfh.next[2:0] != 3'b000) || next_sum[ADDR_W]) begin
            err   <= ERR_ADDR;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (cnt_inc == 8'(MAX_FEATURES)) begin
            err   <= ERR_LOOP;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cur          <= next_sum[ADDR_W-1:0];
            rd_req_valid <= 1'b1;
            rd_req_addr  <= next_sum[ADDR_W-1:0];
            state        <= ST_REQ;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccip_dfh_walker.sv
// Randomized bench for ccip_dfh_walker: a memory-backed MMIO slave, a list-walking
// reference model feeding a scoreboard, and a monitor that checks each done pulse.
module tb_ccip_dfh_walker;
  import ccip_feature_list_pkg::*;

  localparam int ADDR_W = 24;
  localparam int MAXF   = 4;
  localparam int TMO    = 16;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [3:0]        target_type;
  logic [11:0]       target_id;
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_req_ready;
  logic              rd_rsp_valid;
  logic [63:0]       rd_rsp_data;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W-1:0] found_addr;
  logic [63:0]       found_dfh;
  logic [7:0]        feature_count;
  logic [1:0]        err;

  ccip_dfh_walker #(.ADDR_W(ADDR_W), .MAX_FEATURES(MAXF), .RSP_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .target_type(target_type), .target_id(target_id),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .busy(busy), .done(done), .found(found), .found_addr(found_addr),
    .found_dfh(found_dfh), .feature_count(feature_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] mk(logic [3:0] ty, logic eol, logic [23:0] nxt, logic [11:0] id);
    t_ccip_dfh d;
    d = '0;
    d.f_type = ty;
    d.eol    = eol;
    d.next   = nxt;
    d.id     = id;
    return d;
  endfunction

  // Unpopulated addresses read back as an end-of-list header nobody targets.
  logic [63:0] mem [longint];

  function automatic logic [63:0] rd_mem(longint a);
    if (mem.exists(a)) return mem[a];
    return mk(4'h0, 1'b1, 24'h0, 12'hFFF);
  endfunction

  typedef struct {
    logic        found;
    logic [23:0] addr;
    logic [63:0] dfh;
    logic [7:0]  cnt;
    logic [1:0]  err;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] addr_q[$];

  // Walks the list the way a driver would; read number `drop` is never answered.
  function automatic void model(longint base, logic [3:0] ty, logic [11:0] id, int drop);
    exp_t      e;
    longint    cur;
    int        cnt;
    t_ccip_dfh d;
    e.found = 1'b0; e.addr = '0; e.dfh = '0; e.cnt = '0; e.err = ERR_NONE;
    cur = base;
    cnt = 0;
    for (int r = 0; r < 1000; r++) begin
      addr_q.push_back(cur[23:0]);
      if (r == drop) begin e.err = ERR_TIMEOUT; break; end
      d = t_ccip_dfh'(rd_mem(cur));
      cnt++;
      if (d.f_type == ty && d.id == id) begin
        e.found = 1'b1; e.addr = cur[23:0]; e.dfh = d;
        break;
      end
      if (d.eol || d.next == 0) break;
      if ((d.next % 8) != 0 || cur + longint'(d.next) >= (longint'(1) << ADDR_W)) begin
        e.err = ERR_ADDR;
        break;
      end
      if (cnt == MAXF) begin e.err = ERR_LOOP; break; end
      cur = cur + longint'(d.next);
    end
    e.cnt = 8'(cnt);
    exp_q.push_back(e);
  endfunction

  // MMIO slave: random ready, 1-3 cycle response delay, optional dropped read.
  int          drop_idx = -1;
  int          rd_idx = 0;
  int          acc_cyc = 0;
  logic        pend = 1'b0;
  int          pdly = 0;
  logic [23:0] paddr;
  logic        inject = 1'b0;
  logic [63:0] inject_data = '0;

  initial begin
    rd_req_ready = 1'b0;
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    forever begin
      @(negedge clk);
      rd_rsp_valid = 1'b0;
      if (!reset_n) pend = 1'b0;
      else if (pend) begin
        if (pdly == 0) begin
          rd_rsp_valid = 1'b1;
          rd_rsp_data  = rd_mem(longint'(paddr));
          pend = 1'b0;
        end else pdly--;
      end
      if (inject) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = inject_data;
      end
      rd_req_ready = ($urandom_range(0, 3) != 0);
      if (reset_n && rd_req_valid && rd_req_ready) begin
        if (addr_q.size() == 0) chk("unexpected_req", {40'h0, rd_req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("req_addr", {40'h0, rd_req_addr}, {40'h0, addr_q.pop_front()});
        acc_cyc = cyc + 1;
        if (rd_idx != drop_idx) begin
          pend  = 1'b1;
          pdly  = $urandom_range(0, 2);
          paddr = rd_req_addr;
        end
        rd_idx++;
      end
    end
  end

  int done_cnt = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'h1, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("found", {63'h0, found}, {63'h0, e.found});
          chk("found_addr", {40'h0, found_addr}, {40'h0, e.addr});
          chk("found_dfh", found_dfh, e.dfh);
          chk("feature_count", {56'h0, feature_count}, {56'h0, e.cnt});
          chk("err", {62'h0, err}, {62'h0, e.err});
          chk("busy_at_done", {63'h0, busy}, 64'h0);
          chk("reads_left", 64'(addr_q.size()), 64'h0);
          if (e.err == ERR_TIMEOUT) chk("timeout_latency", 64'(cyc - acc_cyc), 64'(TMO));
        end
      end
    end
  end

  task automatic run_walk(longint base, logic [3:0] ty, logic [11:0] id, int drop,
                          bit spurious, bit start_in_done);
    bit seen;
    @(negedge clk);
    drop_idx = drop;
    rd_idx   = 0;
    model(base, ty, id, drop);
    base_addr   = base[23:0];
    target_type = ty;
    target_id   = id;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {63'h0, busy}, 64'h1);
    if (spurious) begin
      base_addr   = 24'($urandom_range(0, 24'hFFFFFF));
      target_type = 4'($urandom_range(0, 15));
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) begin
      chk("done_timeout", 64'h0, 64'h1);
      exp_q.delete();
      addr_q.delete();
      return;
    end
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse_width", {63'h0, done}, 64'h0);
    if (start_in_done) begin
      chk("start_in_done_busy", {63'h0, busy}, 64'h0);
      chk("start_in_done_req", {63'h0, rd_req_valid}, 64'h0);
    end
  endtask

  task automatic reset_midwalk();
    int n;
    bit acc;
    mem.delete();
    mem[0] = mk(FTYP_AFU, 1'b0, 24'h100, 12'h001);
    @(negedge clk);
    exp_q.delete();
    addr_q.delete();
    addr_q.push_back(24'h0);
    drop_idx = 0;
    rd_idx   = 0;
    base_addr = '0; target_type = FTYP_BBB; target_id = 12'h02A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (rd_idx >= 1) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst_req_accepted", {63'h0, acc}, 64'h1);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {63'h0, busy}, 64'h1);
    n = done_cnt;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("in_reset_busy", {63'h0, busy}, 64'h0);
    chk("in_reset_req", {63'h0, rd_req_valid}, 64'h0);
    reset_n = 1'b1;
    addr_q.delete();
    inject_data = mk(FTYP_BBB, 1'b1, 24'h0, 12'h02A);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", {63'h0, busy}, 64'h0);
    chk("post_rst_found", {63'h0, found}, 64'h0);
    chk("post_rst_count", {56'h0, feature_count}, 64'h0);
    chk("post_rst_err", {62'h0, err}, 64'h0);
    chk("post_rst_no_done", 64'(done_cnt - n), 64'h0);
    drop_idx = -1;
  endtask

  initial begin
    longint cur;
    longint base;
    int     n;
    logic [23:0] nxt;
    logic   eol;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; target_type = '0; target_id = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_req_valid", {63'h0, rd_req_valid}, 64'h0);
    chk("rst_req_addr", {40'h0, rd_req_addr}, 64'h0);
    chk("rst_found", {63'h0, found}, 64'h0);
    chk("rst_found_addr", {40'h0, found_addr}, 64'h0);
    chk("rst_found_dfh", found_dfh, 64'h0);
    chk("rst_count", {56'h0, feature_count}, 64'h0);
    chk("rst_err", {62'h0, err}, 64'h0);
    reset_n = 1'b1;

    mem.delete();
    mem[0]      = mk(FTYP_AFU, 1'b0, 24'h100, 12'h001);
    mem['h100]  = mk(FTYP_BBB, 1'b0, 24'h080, 12'h02A);
    mem['h180]  = mk(FTYP_BBB, 1'b1, 24'h000, 12'h02B);
    run_walk(0, FTYP_BBB, 12'h02A, -1, 1'b1, 1'b1);
    run_walk(0, FTYP_BBB, 12'h099, -1, 1'b0, 1'b0);
    run_walk(0, FTYP_BBB, 12'h099, 1, 1'b0, 1'b1);

    mem.delete();
    for (int i = 0; i < 6; i++) mem[longint'(i) * 'h100] = mk(FTYP_PVT, 1'b0, 24'h100, 12'h005);
    run_walk(0, FTYP_PVT, 12'h077, -1, 1'b0, 1'b0);

    mem.delete();
    mem['h40] = mk(FTYP_AFU, 1'b0, 24'h104, 12'h001);
    run_walk('h40, FTYP_BBB, 12'h001, -1, 1'b0, 1'b0);

    mem.delete();
    mem['hFFFF00] = mk(FTYP_AFU, 1'b0, 24'h200, 12'h001);
    run_walk('hFFFF00, FTYP_BBB, 12'h001, -1, 1'b0, 1'b0);

    mem.delete();
    mem['h8] = mk(FTYP_BBB, 1'b1, 24'h0, 12'h033);
    run_walk('h8, FTYP_BBB, 12'h033, -1, 1'b0, 1'b0);

    reset_midwalk();
    mem.delete();
    mem[0]     = mk(FTYP_AFU, 1'b0, 24'h100, 12'h001);
    mem['h100] = mk(FTYP_BBB, 1'b0, 24'h080, 12'h02A);
    run_walk(0, FTYP_BBB, 12'h02A, -1, 1'b0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      mem.delete();
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 7) == 0) base = 'hFFF000 + longint'($urandom_range(0, 'h1FF)) * 8;
      else base = longint'($urandom_range(0, 'h3FFF)) * 8;
      cur = base;
      for (int i = 0; i < n; i++) begin
        nxt = 24'($urandom_range(1, 'h40) * 8);
        if ($urandom_range(0, 9) == 0) nxt = nxt | 24'h4;
        eol = 1'b0;
        if (i == n - 1) begin
          eol = $urandom_range(0, 1) == 1;
          if (!eol && $urandom_range(0, 1) == 1) nxt = 24'h0;
        end
        mem[cur] = mk(4'($urandom_range(1, 3)), eol, nxt, 12'($urandom_range(0, 15)));
        cur = cur + longint'(nxt);
        if (cur >= (longint'(1) << ADDR_W)) break;
      end
      run_walk(base, 4'($urandom_range(1, 3)), 12'($urandom_range(0, 15)),
               ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    repeat (5) @(negedge clk);
    chk("exp_queue_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
